// File: rtl/fu_div_mlane_if.sv
//==============================================================================
// Module : fu_div_pkg / squash_if
// Brief  : Shared FU request/response types and the pipeline squash interface
//          used by the multi-lane divider.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package fu_div_pkg;
    localparam int XLEN  = 64;
    localparam int ID_W  = 8;
    localparam int PRD_W = 7;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_REM  = 2'd2,
        DIV_REMU = 2'd3
    } div_op_e;

    typedef struct packed {
        div_op_e div;
    } fu_op_t;

    typedef enum logic {
        SIZE_W = 1'b0,
        SIZE_D = 1'b1
    } size_e;

    typedef struct packed {
        fu_op_t            op;
        size_e             size;
        logic [XLEN-1:0]   rs1val;
        logic [XLEN-1:0]   rs2val;
        logic [XLEN-1:0]   pc;
        logic [ID_W-1:0]   id;
        logic [PRD_W-1:0]  prd;
    } fu_input_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [ID_W-1:0]   id;
        logic [PRD_W-1:0]  prd;
        logic [XLEN-1:0]   rdval;
    } fu_output_t;
endpackage

interface squash_if;
    logic valid;
    modport master (output valid);
    modport slave  (input  valid);
endinterface

`default_nettype wire

// File: rtl/fu_div_mlane.sv
//==============================================================================
// Module : fu_div_mlane
// Brief  : Multi-lane iterative DIV/DIVU/REM/REMU unit, BPC quotient bits per
//          lane per cycle, one retirement per cycle. Optional macro
//          FU_DIV_EARLY_OUT_EN skips leading zero dividend groups.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module fu_div_mlane
    import fu_div_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int BPC    = 8,
    parameter int NLANES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  fu_input_t  fuinput_i,
    input  logic       fuinput_i_valid,
    output logic       fuinput_i_ready,
    output fu_output_t fuoutput_o,
    output logic       fuoutput_o_valid,
    squash_if.slave    squash_io
);

    localparam int         c_ng = WIDTH / BPC;
    localparam int         c_cw = $clog2(c_ng + 1);
    localparam int         c_lw = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_run  = 2'd1;
    localparam logic [1:0] c_s_done = 2'd2;

    // One restoring step per quotient bit; remainder in the upper half of the result.
    function automatic logic [2*WIDTH-1:0] f_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0]   t;
        logic [WIDTH:0]   dif;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] q;
        r = rem;
        q = quo;
        for (int b = 0; b < BPC; b++) begin
            t   = {r, q[WIDTH-1]};
            q   = {q[WIDTH-2:0], 1'b0};
            dif = t - {1'b0, dvs};
            if (t >= {1'b0, dvs}) begin
                r    = dif[WIDTH-1:0];
                q[0] = 1'b1;
            end else begin
                r = t[WIDTH-1:0];
            end
        end
        return {r, q};
    endfunction

    logic             w_signed, w_is_rem, w_word, w_sa, w_sb;
    logic             w_div0, w_ovf, w_fast, w_neg, w_acc;
    logic [WIDTH-1:0] w_a, w_b, w_abs_a, w_abs_b, w_int_min, w_fast_quo, w_fast_rem;
    logic [c_lw-1:0]  w_acc_idx, w_sel_idx;
    logic [WIDTH-1:0] w_res;

    logic [1:0]       w_lstate [NLANES];
    logic             w_lrem_op[NLANES];
    logic             w_lword  [NLANES];
    logic             w_lneg   [NLANES];
    logic [WIDTH-1:0] w_lquo   [NLANES];
    logic [WIDTH-1:0] w_lrem   [NLANES];
    logic [XLEN-1:0]  w_lpc    [NLANES];
    logic [ID_W-1:0]  w_lid    [NLANES];
    logic [PRD_W-1:0] w_lprd   [NLANES];

    // Operand preparation and fast-path detection on the issuing request.
    always_comb begin
        w_signed = (fuinput_i.op.div == DIV_DIV) || (fuinput_i.op.div == DIV_REM);
        w_is_rem = (fuinput_i.op.div == DIV_REM) || (fuinput_i.op.div == DIV_REMU);
        w_word   = (fuinput_i.size != SIZE_D);
        if (w_word) begin
            w_a       = {{(WIDTH-32){w_signed & fuinput_i.rs1val[31]}}, fuinput_i.rs1val[31:0]};
            w_b       = {{(WIDTH-32){w_signed & fuinput_i.rs2val[31]}}, fuinput_i.rs2val[31:0]};
            w_int_min = {{(WIDTH-31){1'b1}}, {31{1'b0}}};
        end else begin
            w_a       = fuinput_i.rs1val;
            w_b       = fuinput_i.rs2val;
            w_int_min = {1'b1, {(WIDTH-1){1'b0}}};
        end
        w_sa       = w_signed & w_a[WIDTH-1];
        w_sb       = w_signed & w_b[WIDTH-1];
        w_abs_a    = w_sa ? -w_a : w_a;
        w_abs_b    = w_sb ? -w_b : w_b;
        w_div0     = (w_b == '0);
        w_ovf      = w_signed & (w_a == w_int_min) & (&w_b);
        w_fast_quo = '0;
        w_fast_rem = '0;
        if (w_div0) begin
            w_fast_quo = '1;
            w_fast_rem = w_a;
        end else if (w_ovf) begin
            w_fast_quo = w_a;
        end
`ifdef FU_DIV_EARLY_OUT_EN
        w_fast = w_div0 | w_ovf | (w_a == '0);
`else
        w_fast = w_div0 | w_ovf;
`endif
        w_neg = w_fast ? 1'b0 : (w_is_rem ? w_sa : (w_sa ^ w_sb));
    end

    assign w_acc = fuinput_i_valid & fuinput_i_ready & ~squash_io.valid;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        logic [1:0]       r_state, w_state_nx;
        logic             r_rem_op, r_word, r_neg;
        logic [WIDTH-1:0] r_quo, r_rem, r_dvs;
        logic [c_cw-1:0]  r_cnt;
        logic [XLEN-1:0]  r_pc;
        logic [ID_W-1:0]  r_id;
        logic [PRD_W-1:0] r_prd;
        logic             w_take, w_retire, w_norm;
        logic [2*WIDTH-1:0] w_step;

        assign w_take   = w_acc & (w_acc_idx == c_lw'(i));
        assign w_retire = fuoutput_o_valid & (w_sel_idx == c_lw'(i));
        assign w_step   = f_step(r_rem, r_quo, r_dvs);

`ifdef FU_DIV_EARLY_OUT_EN
        // First RUN cycle normalises the dividend to its leading nonzero group.
        logic            r_norm;
        logic [c_cw-1:0] w_ng;
        assign w_norm = r_norm;
        always_comb begin
            w_ng = c_cw'(1);
            for (int g = 0; g < c_ng; g++) begin
                if (|r_quo[g*BPC +: BPC]) w_ng = c_cw'(g + 1);
            end
        end
        always_ff @(posedge clk) begin
            if (w_take)                  r_norm <= 1'b1;
            else if (r_state == c_s_run) r_norm <= 1'b0;
        end
`else
        assign w_norm = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (!rstn) r_state <= c_s_idle;
            else       r_state <= w_state_nx;
        end

        always_comb begin
            w_state_nx = r_state;
            case (r_state)
                c_s_idle: if (w_take) w_state_nx = w_fast ? c_s_done : c_s_run;
                c_s_run:  if (!w_norm && (r_cnt == '0)) w_state_nx = c_s_done;
                c_s_done: if (w_retire) w_state_nx = c_s_idle;
                default:  w_state_nx = c_s_idle;
            endcase
            if (squash_io.valid) w_state_nx = c_s_idle;
        end

        always_ff @(posedge clk) begin
            if (w_take) begin
                r_rem_op <= w_is_rem;
                r_word   <= w_word;
                r_neg    <= w_neg;
                r_pc     <= fuinput_i.pc;
                r_id     <= fuinput_i.id;
                r_prd    <= fuinput_i.prd;
                r_quo    <= w_fast ? w_fast_quo : w_abs_a;
                r_rem    <= w_fast ? w_fast_rem : '0;
                r_dvs    <= w_abs_b;
                r_cnt    <= c_cw'(c_ng - 1);
            end else if (r_state == c_s_run) begin
`ifdef FU_DIV_EARLY_OUT_EN
                if (r_norm) begin
                    r_quo <= r_quo << ((c_ng - int'(w_ng)) * BPC);
                    r_cnt <= w_ng - c_cw'(1);
                end else
`endif
                begin
                    r_quo <= w_step[WIDTH-1:0];
                    r_rem <= w_step[2*WIDTH-1:WIDTH];
                    r_cnt <= r_cnt - c_cw'(1);
                end
            end
        end

        assign w_lstate[i]  = r_state;
        assign w_lrem_op[i] = r_rem_op;
        assign w_lword[i]   = r_word;
        assign w_lneg[i]    = r_neg;
        assign w_lquo[i]    = r_quo;
        assign w_lrem[i]    = r_rem;
        assign w_lpc[i]     = r_pc;
        assign w_lid[i]     = r_id;
        assign w_lprd[i]    = r_prd;
    end

    // Lowest-index DONE lane retires; lowest-index IDLE lane accepts.
    always_comb begin
        fuoutput_o_valid = 1'b0;
        fuinput_i_ready  = 1'b0;
        w_sel_idx        = '0;
        w_acc_idx        = '0;
        for (int i = NLANES - 1; i >= 0; i--) begin
            if (w_lstate[i] == c_s_done) begin
                fuoutput_o_valid = 1'b1;
                w_sel_idx        = c_lw'(i);
            end
            if (w_lstate[i] == c_s_idle) begin
                fuinput_i_ready = 1'b1;
                w_acc_idx       = c_lw'(i);
            end
        end
        w_res = w_lrem_op[w_sel_idx] ? w_lrem[w_sel_idx] : w_lquo[w_sel_idx];
        if (w_lneg[w_sel_idx]) w_res = -w_res;
        if (w_lword[w_sel_idx]) w_res = {{(WIDTH-32){w_res[31]}}, w_res[31:0]};
        fuoutput_o.pc    = w_lpc[w_sel_idx];
        fuoutput_o.id    = w_lid[w_sel_idx];
        fuoutput_o.prd   = w_lprd[w_sel_idx];
        fuoutput_o.rdval = w_res;
    end

endmodule

`default_nettype wire

// File: tb/tb_fu_div_mlane.sv
//==============================================================================
// Module : tb_fu_div_mlane
// Brief  : Directed self-checking bench for fu_div_mlane (honours
//          FU_DIV_EARLY_OUT_EN for expected latencies).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_fu_div_mlane;
    import fu_div_pkg::*;

`ifdef FU_DIV_EARLY_OUT_EN
    localparam int L_M100 = 3;
    localparam int L_WRD  = 6;
    localparam int L_1000 = 4;
    localparam int L_C    = 3;
    localparam int L_9    = 3;
`else
    localparam int L_M100 = 9;
    localparam int L_WRD  = 9;
    localparam int L_1000 = 9;
    localparam int L_C    = 9;
    localparam int L_9    = 9;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    fu_input_t  fin;
    logic       fin_valid;
    logic       fin_ready;
    fu_output_t fout;
    logic       fout_valid;
    int         n_checks = 0;
    int         n_fail   = 0;

    squash_if sq ();

    fu_div_mlane #(.WIDTH(64), .BPC(8), .NLANES(2)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .fuinput_i        (fin),
        .fuinput_i_valid  (fin_valid),
        .fuinput_i_ready  (fin_ready),
        .fuoutput_o       (fout),
        .fuoutput_o_valid (fout_valid),
        .squash_io        (sq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input div_op_e op, input size_e sz, input logic [63:0] a,
                         input logic [63:0] b, input logic [7:0] tag);
        fin.op.div = op;
        fin.size   = sz;
        fin.rs1val = a;
        fin.rs2val = b;
        fin.pc     = {56'h0, tag} << 2;
        fin.id     = tag;
        fin.prd    = tag[6:0];
        fin_valid  = 1'b1;
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic wait_result(input string name, input logic [63:0] exp, input int lat,
                               input logic [7:0] tag);
        int k;
        k = 1;
        while (fout_valid !== 1'b1 && k < 40) begin
            @(posedge clk); @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, k, lat);
        end
        n_checks++;
        if (fout.rdval !== exp) begin
            n_fail++;
            $display("FAIL %s rdval: got %h want %h", name, fout.rdval, exp);
        end
        n_checks++;
        if (fout.id !== tag) begin
            n_fail++;
            $display("FAIL %s id: got %h want %h", name, fout.id, tag);
        end
    endtask

    task automatic do_op(input string name, input div_op_e op, input size_e sz,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int lat, input logic [7:0] tag);
        @(negedge clk);
        drive(op, sz, a, b, tag);
        n_checks++;
        if (fin_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready: got %b want 1", name, fin_ready);
        end
        @(posedge clk); @(negedge clk);
        fin_valid = 1'b0;
        wait_result(name, exp, lat, tag);
        @(posedge clk);
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        fin_valid = 1'b0;
        sq.valid  = 1'b0;
        fin       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (fin_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset ready: got %b want 1", fin_ready);
        end
        n_checks++;
        if (fout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset valid: got %b want 0", fout_valid);
        end
    endtask

    task automatic test_signed();
        do_op("div_m100_7", DIV_DIV, SIZE_D, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, L_M100, 8'h11);
        do_op("rem_m100_7", DIV_REM, SIZE_D, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, L_M100, 8'h12);
    endtask

    task automatic test_word();
        do_op("divuw", DIV_DIVU, SIZE_W, 64'hFFFF_FFFF_8000_0000, 64'd2, 64'h0000_0000_4000_0000, L_WRD, 8'h21);
        do_op("remw_by0", DIV_REM, SIZE_W, -64'sd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1, 8'h22);
    endtask

    task automatic test_fast();
        do_op("div_ovf", DIV_DIV, SIZE_D, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1, 8'h31);
        do_op("rem_ovf", DIV_REM, SIZE_D, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h0, 1, 8'h32);
        do_op("divu_by0", DIV_DIVU, SIZE_D, 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 8'h33);
    endtask

    task automatic test_lanes();
        @(negedge clk);
        drive(DIV_DIVU, SIZE_D, 64'd1000, 64'd3, 8'h41);
        @(posedge clk); @(negedge clk);
        drive(DIV_DIVU, SIZE_D, 64'd50, 64'd5, 8'h42);
        @(posedge clk); @(negedge clk);
        fin_valid = 1'b0;
        n_checks++;
        if (fin_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lanes busy ready: got %b want 0", fin_ready);
        end
        repeat (L_1000 - 2) begin
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if (fout_valid !== 1'b1 || fout.rdval !== 64'd333) begin
            n_fail++;
            $display("FAIL lanes A: got valid=%b rdval=%0d want valid=1 rdval=333", fout_valid, fout.rdval);
        end
        n_checks++;
        if (fin_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lanes retire ready: got %b want 0", fin_ready);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (fout_valid !== 1'b1 || fout.rdval !== 64'd10) begin
            n_fail++;
            $display("FAIL lanes B: got valid=%b rdval=%0d want valid=1 rdval=10", fout_valid, fout.rdval);
        end
        n_checks++;
        if (fin_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lanes reuse ready: got %b want 1", fin_ready);
        end
        drive(DIV_DIVU, SIZE_D, 64'd20, 64'd4, 8'h43);
        @(posedge clk); @(negedge clk);
        fin_valid = 1'b0;
        n_checks++;
        if (fout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lanes after B valid: got %b want 0", fout_valid);
        end
        wait_result("lanes_C", 64'd5, L_C, 8'h43);
        @(posedge clk);
    endtask

    task automatic test_squash();
        bit seen;
        @(negedge clk);
        drive(DIV_DIVU, SIZE_D, 64'd1000, 64'd3, 8'h51);
        @(posedge clk); @(negedge clk);
        drive(DIV_DIVU, SIZE_D, 64'd50, 64'd5, 8'h52);
        @(posedge clk); @(negedge clk);
        fin_valid = 1'b0;
        sq.valid  = 1'b1;
        @(posedge clk); @(negedge clk);
        sq.valid = 1'b0;
        n_checks++;
        if (fin_ready !== 1'b1 || fout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL squash state: got ready=%b valid=%b want ready=1 valid=0", fin_ready, fout_valid);
        end
        drive(DIV_DIVU, SIZE_D, 64'd9, 64'd3, 8'h53);
        sq.valid = 1'b1;
        @(posedge clk); @(negedge clk);
        fin_valid = 1'b0;
        sq.valid  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (fout_valid === 1'b1) seen = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL squash quiet: got output valid after squash, want none");
        end
        n_checks++;
        if (fin_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL squash ready: got %b want 1", fin_ready);
        end
        do_op("div_9_3", DIV_DIV, SIZE_D, 64'd9, 64'd3, 64'd3, L_9, 8'h54);
    endtask

`ifdef FU_DIV_EARLY_OUT_EN
    task automatic test_early_out();
        do_op("eo_100_7", DIV_DIVU, SIZE_D, 64'd100, 64'd7, 64'd14, 3, 8'h61);
        do_op("eo_0_5", DIV_DIVU, SIZE_D, 64'd0, 64'd5, 64'd0, 1, 8'h62);
    endtask
`endif

    initial begin
        test_reset();
        test_signed();
        test_word();
        test_fast();
        test_lanes();
        test_squash();
`ifdef FU_DIV_EARLY_OUT_EN
        test_early_out();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
